// File: rtl/logmux_if.sv
// logmux_if -- bundle of the source-side and uplink-side signals of the
// logger multiplexer.
//
//   ch_en      per-channel enable, looked at only when a record is granted
//   src_valid  per-channel byte valid, held by the source until acknowledged
//   src_data   per-channel byte, channel i on bits [8i+7:8i]
//   src_next   one-cycle acknowledge pulse back to the granted channel
//   tx_valid   byte valid toward the uplink
//   tx_data    byte toward the uplink
//   tx_next    uplink acknowledge, byte moves when tx_valid && tx_next
//   busy       a record is in progress
//   cur_ch     currently / most recently granted channel
//
// The arbiter connects through the slave modport; the logger/uplink side
// (or a bench) uses the master modport.
interface logmux_if #(
   parameter int nch = 4
);
   logic [nch-1:0]   ch_en;
   logic [nch-1:0]   src_valid;
   logic [8*nch-1:0] src_data;
   logic [nch-1:0]   src_next;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_next;
   logic             busy;
   logic [3:0]       cur_ch;

   modport slave (
      input  ch_en, src_valid, src_data, tx_next,
      output src_next, tx_valid, tx_data, busy, cur_ch
   );

   modport master (
      output ch_en, src_valid, src_data, tx_next,
      input  src_next, tx_valid, tx_data, busy, cur_ch
   );
endinterface

// File: rtl/logmux_arbiter.sv
// logmux_arbiter -- round-robin arbiter sharing one byte-serial debug uplink
// between nch change-logger channels. Each grant covers one whole record:
// a header byte {hdr_tag, channel} followed by exactly bpr bytes taken from
// the granted channel.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   logmux_if.slave: ch_en/src_valid/src_data/src_next toward the
//         loggers, tx_valid/tx_data/tx_next toward the uplink, plus the
//         busy and cur_ch status outputs.
//
// There is a single output byte register: a source byte is only fetched
// once the previous uplink byte has been acknowledged.
module logmux_arbiter #(
   parameter int         nch     = 4,
   parameter int         bpr     = 2,
   parameter logic [3:0] hdr_tag = 4'hA
) (
   input logic     clk,
   input logic     rst,
   logmux_if.slave bus
);
   localparam int iw = (nch > 1) ? $clog2(nch) : 1;
   localparam int cw = $clog2(bpr) + 1;

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_hdr  = 2'd1;
   localparam logic [1:0] st_data = 2'd2;

   logic [1:0]     state_reg;
   logic [cw-1:0]  cnt_reg;
   logic [3:0]     cur_ch_reg;
   logic           tx_valid_reg;
   logic [7:0]     tx_data_reg;
   logic [nch-1:0] src_next_reg;

   logic [nch-1:0] req;
   logic [3:0]     winner;
   logic           found;
   logic [iw-1:0]  idx;
   logic [iw-1:0]  sel;
   logic [7:0]     src_byte [nch];

   genvar gi;
   generate
      for (gi = 0; gi < nch; gi++) begin : g_unpack
         assign src_byte[gi] = bus.src_data[8*gi +: 8];
      end
   endgenerate

   // cur_ch never exceeds nch-1, so its low bits address the channel.
   assign sel = cur_ch_reg[iw-1:0];

   // Round-robin pick: scan upward from the channel after the last grant,
   // wrapping at nch, and keep the first requester found.
   always_comb begin
      req    = bus.src_valid & bus.ch_en;
      winner = cur_ch_reg;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= nch; k++) begin
         idx = iw'((int'(cur_ch_reg) + k) % nch);
         if (!found && req[idx]) begin
            winner = 4'(idx);
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= st_idle;
         cnt_reg      <= '0;
         cur_ch_reg   <= 4'(nch - 1);
         tx_valid_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
         src_next_reg <= '0;
      end else begin
         // Acknowledges are single-cycle pulses.
         src_next_reg <= '0;
         case (state_reg)
            st_idle: begin
               if (|req) begin
                  cur_ch_reg   <= winner;
                  tx_data_reg  <= {hdr_tag, winner};
                  tx_valid_reg <= 1'b1;
                  state_reg    <= st_hdr;
               end
            end
            st_hdr: begin
               if (tx_valid_reg && bus.tx_next) begin
                  tx_valid_reg <= 1'b0;
                  cnt_reg      <= '0;
                  state_reg    <= st_data;
               end
            end
            st_data: begin
               // The source still shows the consumed byte while its
               // acknowledge is high, so that cycle is skipped for capture.
               if (!tx_valid_reg && bus.src_valid[sel] && !src_next_reg[sel]) begin
                  tx_data_reg       <= src_byte[sel];
                  tx_valid_reg      <= 1'b1;
                  src_next_reg[sel] <= 1'b1;
               end
               if (tx_valid_reg && bus.tx_next) begin
                  tx_valid_reg <= 1'b0;
                  if (cnt_reg == cw'(bpr - 1)) begin
                     state_reg <= st_idle;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            default: state_reg <= st_idle;
         endcase
      end
   end

   assign bus.tx_valid = tx_valid_reg;
   assign bus.tx_data  = tx_data_reg;
   assign bus.src_next = src_next_reg;
   assign bus.busy     = (state_reg != st_idle);
   assign bus.cur_ch   = cur_ch_reg;
endmodule

// File: tb/tb_logmux_arbiter.sv
// tb_logmux_arbiter -- self-checking bench for logmux_arbiter (nch=4, bpr=2).
// Sources are modelled as byte queues; a transaction-level monitor predicts
// each grant from the requests driven while the arbiter is idle (modulo
// scan from the last grant), checks every uplink data byte against the
// bytes the sources produced, record length, output hold under
// backpressure and acknowledge targeting.
module tb_logmux_arbiter;
   localparam int         nch_c     = 4;
   localparam int         bpr_c     = 2;
   localparam logic [3:0] hdr_tag_c = 4'hA;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logmux_if #(.nch(nch_c)) bus ();

   logmux_arbiter #(.nch(nch_c), .bpr(bpr_c), .hdr_tag(hdr_tag_c)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [3:0]  load;
      logic [3:0]  reps;
      logic [3:0]  n;
      logic [63:0] hdr;
   } vec_t;
   vec_t vecs [8];

   int checks = 0;
   int errors = 0;

   logic [7:0] src_q [nch_c][$];
   logic [7:0] exp_q [nch_c][$];
   logic [7:0] hdr_log [$];
   logic [7:0] tx_log [$];
   int         pulse_cnt [nch_c];

   logic [3:0] en_v;
   logic [3:0] stall_v;
   logic       tx_next_v;

   logic       mon_on;
   logic       in_rec, hdr_pending, expect_idle, idle_pending;
   logic [3:0] idle_req;
   int         rr_last, rec_ch, rec_cnt;
   logic       prev_txv, prev_txn;
   logic [7:0] prev_txd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= nch_c; k++) begin
         int c;
         c = (last + k) % nch_c;
         if (r[c]) return c;
      end
      return last;
   endfunction

   function automatic int q_total();
      int s = 0;
      for (int i = 0; i < nch_c; i++) s += src_q[i].size();
      return s;
   endfunction

   task automatic push_rec(input int c, input logic [15:0] b);
      src_q[c].push_back(b[15:8]);
      exp_q[c].push_back(b[15:8]);
      src_q[c].push_back(b[7:0]);
      exp_q[c].push_back(b[7:0]);
   endtask

   task automatic mon_reset();
      in_rec       = 1'b0;
      hdr_pending  = 1'b0;
      expect_idle  = 1'b0;
      idle_pending = 1'b0;
      idle_req     = 4'h0;
      rr_last      = nch_c - 1;
      rec_ch       = 0;
      rec_cnt      = 0;
      prev_txv     = 1'b0;
      prev_txn     = 1'b0;
      prev_txd     = 8'h00;
   endtask

   task automatic clear_pulses();
      for (int i = 0; i < nch_c; i++) pulse_cnt[i] = 0;
   endtask

   // One clock: observe outputs at the falling edge, let sources consume,
   // drive the next inputs, then account for the transfer those inputs cause.
   task automatic cyc();
      logic [31:0] sd;
      logic [3:0]  sv;
      int          w;
      @(negedge clk);
      if (mon_on) begin
         if (idle_pending) begin
            idle_pending = 1'b0;
            if (idle_req != 4'h0) begin
               w = rr_pick(idle_req, rr_last);
               chk("grant", {bus.busy, bus.tx_valid, bus.tx_data, bus.cur_ch},
                   {1'b1, 1'b1, hdr_tag_c, 4'(w), 4'(w)});
               rr_last     = w;
               in_rec      = 1'b1;
               hdr_pending = 1'b1;
               rec_ch      = w;
               rec_cnt     = 0;
            end else begin
               chk("idle", {31'd0, bus.busy}, 32'd0);
            end
         end else if (expect_idle) begin
            expect_idle = 1'b0;
            in_rec      = 1'b0;
            chk("rec_end", {30'd0, bus.busy, bus.tx_valid}, 32'd0);
         end else if (in_rec) begin
            chk("in_record", {31'd0, bus.busy}, 32'd1);
         end
         if (prev_txv && !prev_txn)
            chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_txd});
         if (bus.src_next != 4'h0)
            chk("ack_target", {in_rec, hdr_pending, bus.src_next},
                {1'b1, 1'b0, 4'(1 << rec_ch)});
      end
      for (int i = 0; i < nch_c; i++) begin
         if (bus.src_next[i]) begin
            pulse_cnt[i]++;
            if (src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
      end
      sd = '0;
      sv = '0;
      for (int i = 0; i < nch_c; i++) begin
         if (src_q[i].size() > 0) begin
            sd[8*i +: 8] = src_q[i][0];
            sv[i]        = !stall_v[i];
         end
      end
      bus.src_data  = sd;
      bus.src_valid = sv;
      bus.ch_en     = en_v;
      bus.tx_next   = tx_next_v;
      if (bus.tx_valid && tx_next_v) begin
         $display("xfer t=%0t byte=%02h ch=%0d", $time, bus.tx_data, bus.cur_ch);
         tx_log.push_back(bus.tx_data);
         if (mon_on) begin
            if (hdr_pending) begin
               hdr_pending = 1'b0;
               hdr_log.push_back(bus.tx_data);
            end else if (in_rec && !expect_idle) begin
               if (exp_q[rec_ch].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL data_extra actual=%02h required=no byte", bus.tx_data);
               end else begin
                  chk("data", {24'd0, bus.tx_data}, {24'd0, exp_q[rec_ch].pop_front()});
               end
               rec_cnt++;
               if (rec_cnt == bpr_c) expect_idle = 1'b1;
            end else begin
               checks++;
               errors++;
               $display("FAIL spurious_xfer actual=%02h required=no transfer", bus.tx_data);
            end
         end
      end
      prev_txv = bus.tx_valid;
      prev_txd = bus.tx_data;
      prev_txn = tx_next_v;
      if (mon_on && !in_rec) begin
         idle_pending = 1'b1;
         idle_req     = sv & en_v;
      end
   endtask

   task automatic drain(input int budget);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < budget) begin
         cyc();
         n++;
         done = (q_total() == 0) && !in_rec && !bus.busy;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d cycles required=idle within %0d", n, budget);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{load: 4'b1111, reps: 4'd1, n: 4'd4, hdr: 64'hA2A3A0A1_00000000};
      vecs[1] = '{load: 4'b1001, reps: 4'd1, n: 4'd2, hdr: 64'hA3A00000_00000000};
      vecs[2] = '{load: 4'b0110, reps: 4'd1, n: 4'd2, hdr: 64'hA1A20000_00000000};
      vecs[3] = '{load: 4'b1000, reps: 4'd1, n: 4'd1, hdr: 64'hA3000000_00000000};
      vecs[4] = '{load: 4'b1001, reps: 4'd4, n: 4'd8, hdr: 64'hA0A3A0A3_A0A3A0A3};
      vecs[5] = '{load: 4'b0001, reps: 4'd1, n: 4'd1, hdr: 64'hA0000000_00000000};
      vecs[6] = '{load: 4'b0101, reps: 4'd1, n: 4'd2, hdr: 64'hA2A00000_00000000};
      vecs[7] = '{load: 4'b1011, reps: 4'd1, n: 4'd3, hdr: 64'hA1A3A000_00000000};

      rst           = 1'b1;
      mon_on        = 1'b0;
      en_v          = 4'h0;
      stall_v       = 4'h0;
      tx_next_v     = 1'b0;
      bus.ch_en     = '0;
      bus.src_valid = '0;
      bus.src_data  = '0;
      bus.tx_next   = 1'b0;
      clear_pulses();
      mon_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
      chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
      chk("rst_src_next", {28'd0, bus.src_next}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_cur_ch", {28'd0, bus.cur_ch}, 32'd3);
      rst = 1'b0;
      mon_reset();
      mon_on = 1'b1;

      // Single source on ch1
      en_v      = 4'b0010;
      tx_next_v = 1'b1;
      tx_log.delete();
      clear_pulses();
      push_rec(1, 16'h3492);
      drain(100);
      chk("single_len", tx_log.size(), 32'd3);
      chk("single_b0", {24'd0, tx_log[0]}, 32'hA1);
      chk("single_b1", {24'd0, tx_log[1]}, 32'h34);
      chk("single_b2", {24'd0, tx_log[2]}, 32'h92);
      chk("single_acks", pulse_cnt[1], 32'd2);
      chk("single_busy", {31'd0, bus.busy}, 32'd0);

      // Table of arbitration scenarios, expected header order per entry
      for (int e = 0; e < 8; e++) begin
         hdr_log.delete();
         en_v      = 4'hF;
         stall_v   = 4'h0;
         tx_next_v = 1'b1;
         for (int r = 0; r < int'(vecs[e].reps); r++)
            for (int c = 0; c < nch_c; c++)
               if (vecs[e].load[c]) push_rec(c, 16'($urandom));
         drain(400);
         chk($sformatf("vec%0d_count", e), hdr_log.size(), 32'(vecs[e].n));
         for (int k = 0; k < int'(vecs[e].n); k++)
            chk($sformatf("vec%0d_hdr%0d", e, k), {24'd0, hdr_log[k]},
                {24'd0, vecs[e].hdr[63-8*k -: 8]});
      end

      // Backpressure on a pending header
      hdr_log.delete();
      tx_log.delete();
      clear_pulses();
      tx_next_v = 1'b0;
      push_rec(2, 16'($urandom));
      n = 0;
      do begin
         cyc();
         n++;
      end while (!bus.tx_valid && n < 5);
      chk("bp_hdr_appears", {31'd0, bus.tx_valid}, 32'd1);
      repeat (10) begin
         cyc();
         chk("bp_stall", {bus.tx_valid, bus.tx_data, bus.src_next}, {1'b1, 8'hA2, 4'h0});
      end
      tx_next_v = 1'b1;
      drain(100);
      chk("bp_hdrs", hdr_log.size(), 32'd1);
      chk("bp_hdr", {24'd0, hdr_log[0]}, 32'hA2);
      chk("bp_len", tx_log.size(), 32'd3);
      chk("bp_acks", pulse_cnt[2], 32'd2);

      // Atomicity: drop ch2 enable after its header
      hdr_log.delete();
      en_v = 4'hF;
      push_rec(2, 16'($urandom));
      n = 0;
      do begin
         cyc();
         n++;
      end while (!(in_rec && !hdr_pending) && n < 10);
      chk("atom_hdr_sent", {31'd0, in_rec && !hdr_pending}, 32'd1);
      en_v = 4'b1011;
      push_rec(1, 16'($urandom));
      push_rec(2, 16'($urandom));
      repeat (40) cyc();
      chk("atom_hdrs", hdr_log.size(), 32'd2);
      chk("atom_hdr0", {24'd0, hdr_log[0]}, 32'hA2);
      chk("atom_hdr1", {24'd0, hdr_log[1]}, 32'hA1);
      chk("atom_ch2_left", src_q[2].size(), 32'd2);
      en_v = 4'hF;
      drain(100);
      chk("atom_hdr2", {24'd0, hdr_log[2]}, 32'hA2);

      // Source stall mid-record
      hdr_log.delete();
      clear_pulses();
      push_rec(0, 16'($urandom));
      n = 0;
      do begin
         cyc();
         n++;
      end while (pulse_cnt[0] < 1 && n < 10);
      chk("stall_first_ack", pulse_cnt[0], 32'd1);
      stall_v = 4'b0001;
      push_rec(1, 16'($urandom));
      repeat (20) cyc();
      chk("stall_hdrs", hdr_log.size(), 32'd1);
      chk("stall_wait", {bus.busy, bus.tx_valid, bus.cur_ch}, {1'b1, 1'b0, 4'd0});
      stall_v = 4'h0;
      drain(100);
      chk("stall_hdrs_after", hdr_log.size(), 32'd2);
      chk("stall_hdr1", {24'd0, hdr_log[1]}, 32'hA1);

      // Randomised traffic
      for (int t = 0; t < 1500; t++) begin
         tx_next_v = ($urandom_range(9) < 7);
         if ($urandom_range(15) == 0) en_v = 4'($urandom) | 4'b0001;
         if ($urandom_range(7) == 0) stall_v = 4'($urandom) & 4'($urandom);
         if ($urandom_range(3) == 0) begin
            int c;
            c = $urandom_range(nch_c - 1);
            if (src_q[c].size() < 6) push_rec(c, 16'($urandom));
         end
         cyc();
      end
      en_v      = 4'hF;
      stall_v   = 4'h0;
      tx_next_v = 1'b1;
      drain(1000);

      // Asynchronous reset in the middle of a record
      push_rec(1, 16'($urandom));
      n = 0;
      do begin
         cyc();
         n++;
      end while (bus.src_next == 4'h0 && n < 20);
      chk("arst_ack_seen", {31'd0, bus.src_next != 4'h0}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_now", {bus.tx_valid, bus.src_next, bus.busy, bus.cur_ch},
          {1'b0, 4'h0, 1'b0, 4'd3});
      mon_on = 1'b0;
      @(negedge clk);
      for (int i = 0; i < nch_c; i++) begin
         src_q[i].delete();
         exp_q[i].delete();
      end
      bus.src_valid = '0;
      bus.src_data  = '0;
      @(negedge clk);
      rst = 1'b0;
      mon_reset();
      mon_on = 1'b1;
      hdr_log.delete();
      push_rec(0, 16'($urandom));
      push_rec(3, 16'($urandom));
      cyc();
      cyc();
      chk("arst_fresh_hdr", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hA0});
      drain(100);
      chk("arst_hdrs", hdr_log.size(), 32'd2);
      chk("arst_hdr0", {24'd0, hdr_log[0]}, 32'hA0);
      chk("arst_hdr1", {24'd0, hdr_log[1]}, 32'hA3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
